seq_signed_mult: RTL and testbench

Parametrised multi-cycle integer multiplier for the RISC datapath's multiply unit. Each operand is independently signed or unsigned, so one block covers MUL/MULH/MULHSU/MULHU. It trades latency for area: one partial product per clock, with a start/busy/done handshake to the execute-stage controller. The result is the exact 2·WIDTH-bit product, modulo 2^(2·WIDTH).

---
 rtl/mult_pkg.sv | 20 ++
 rtl/twos_abs.sv | 20 ++
 rtl/seq_signed_mult.sv | 121 ++++++++++++
 tb/tb_seq_signed_mult.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential signed/unsigned multiplier.
//   state_t   : control FSM states
//   cnt_width : bit counter width able to hold 0..width
// ----------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/twos_abs.sv
// ----------------------------------------------------------------------------
// twos_abs
// Combinational conditional two's-complement negate: o_val = i_neg ? -i_val : i_val
// (modulo 2^W). Used for operand magnitudes and for the final sign fix.
// Ports:
//   i_val  [W-1:0]  value to conditionally negate
//   i_neg           1 = negate
//   o_val  [W-1:0]  result
// ----------------------------------------------------------------------------
module twos_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/seq_signed_mult.sv
// ----------------------------------------------------------------------------
// seq_signed_mult
// Multi-cycle shift-and-add multiplier, one partial product per clock.
// Each operand is independently signed or unsigned; the result is the exact
// 2*WIDTH-bit product. Magnitudes are multiplied unsigned and the sign is
// applied in a single FIX cycle.
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start              request, accepted in IDLE or DONE
//   x, y               multiplicand / multiplier (sampled with start)
//   x_signed, y_signed 1 = operand is two's complement
//   busy               high in CALC and FIX
//   done               one-cycle pulse, prod valid
//   prod  [2*WIDTH-1:0] product, held until the next FIX
// ----------------------------------------------------------------------------
module seq_signed_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 x_signed,
    input  logic                 y_signed,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = cnt_width(WIDTH);
    localparam int W2 = 2 * WIDTH;

    state_t             r_state;
    state_t             w_next;
    logic [W2:0]        r_acc;      // {upper partial sum (WIDTH+1), multiplier (WIDTH)}
    logic [WIDTH-1:0]   r_mcand;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [W2-1:0]      r_prod;

    logic               w_x_neg;
    logic               w_y_neg;
    logic [WIDTH-1:0]   w_mag_x;
    logic [WIDTH-1:0]   w_mag_y;
    logic [W2-1:0]      w_fixed;
    logic [WIDTH:0]     w_upper;
    logic               w_accept;
    logic               w_last;

    assign w_x_neg = x_signed & x[WIDTH-1];
    assign w_y_neg = y_signed & y[WIDTH-1];

    twos_abs #(.W(WIDTH)) u_abs_x (.i_val(x), .i_neg(w_x_neg), .o_val(w_mag_x));
    twos_abs #(.W(WIDTH)) u_abs_y (.i_val(y), .i_neg(w_y_neg), .o_val(w_mag_y));
    twos_abs #(.W(W2))    u_fix   (.i_val(r_acc[W2-1:0]), .i_neg(r_neg), .o_val(w_fixed));

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Upper half before the add is always < 2^WIDTH (top bit was shifted in
    // as 0), so the WIDTH+1-bit sum cannot overflow.
    assign w_upper = r_acc[W2:WIDTH] + (r_acc[0] ? {1'b0, r_mcand} : '0);

    // NOTE: combinational next-state assigns a default first so every path
    // drives w_next and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CALC;
            CALC:    if (w_last) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = start ? CALC : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_prod  <= '0;
        end else begin
            // busy/done are registered from the next state so they line up
            // with r_state without a decode after the flops.
            r_busy <= (w_next == CALC) || (w_next == FIX);
            r_done <= (w_next == DONE);
            if (w_accept) begin
                r_mcand <= w_mag_x;
                r_acc   <= {{(WIDTH + 1){1'b0}}, w_mag_y};
                r_cnt   <= '0;
                r_neg   <= w_x_neg ^ w_y_neg;
            end else if (r_state == CALC) begin
                r_acc <= {1'b0, w_upper, r_acc[WIDTH-1:1]};
                r_cnt <= r_cnt + CW'(1);
            end else if (r_state == FIX) begin
                r_prod <= w_fixed;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign prod = r_prod;

endmodule

// File: tb/tb_seq_signed_mult.sv
// ----------------------------------------------------------------------------
// tb_seq_signed_mult
// Directed checks of seq_signed_mult at WIDTH = 32 and WIDTH = 8, plus a short
// run of random operands against an exact-product model.
// ----------------------------------------------------------------------------
module tb_seq_signed_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic [31:0] x = '0, y = '0;
    logic        xs = 1'b0, ys = 1'b0;
    logic        busy, done;
    logic [63:0] prod;

    logic        start8 = 1'b0;
    logic [7:0]  x8 = '0, y8 = '0;
    logic        xs8 = 1'b0, ys8 = 1'b0;
    logic        busy8, done8;
    logic [15:0] prod8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_signed_mult #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .x_signed(xs), .y_signed(ys), .busy(busy), .done(done), .prod(prod)
    );

    seq_signed_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8),
        .x_signed(xs8), .y_signed(ys8), .busy(busy8), .done(done8), .prod(prod8)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model32(input logic [31:0] a, b, input logic as, bs);
        logic [63:0] ea, eb;
        ea = as ? {{32{a[31]}}, a} : {32'b0, a};
        eb = bs ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] a, b, input logic as, bs);
        logic [15:0] ea, eb;
        ea = as ? {{8{a[7]}}, a} : {8'b0, a};
        eb = bs ? {{8{b[7]}}, b} : {8'b0, b};
        return ea * eb;
    endfunction

    // One operation on the 32-bit DUT; lat counts edges from the sampling
    // edge (1) to the edge after which done is seen; -1 on timeout.
    task automatic op32(input logic [31:0] a, b, input logic as, bs,
                        output logic [63:0] p, output int lat);
        @(negedge clk);
        x = a; y = b; xs = as; ys = bs; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        p = prod;
    endtask

    task automatic op8(input logic [7:0] a, b, input logic as, bs,
                       output logic [15:0] p, output int lat);
        @(negedge clk);
        x8 = a; y8 = b; xs8 = as; ys8 = bs; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done8) lat = -1;
        p = prod8;
    endtask

    initial begin
        logic [63:0] p;
        logic [15:0] p8;
        int          lat;
        int          n_done;
        int          t_done[3];
        logic [31:0] ra, rb;
        logic        ras, rbs;
        logic [7:0]  ra8, rb8;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy",  busy, 1'b0);
        check("reset_done",  done, 1'b0);
        check("reset_prod",  prod, 64'h0);
        check("reset_prod8", prod8, 16'h0);

        // Directed WIDTH=32
        op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, p, lat);
        check("ss_m1_m1", p, 64'h0000000000000001);
        check("latency32", lat, 34);
        op32(32'h80000000, 32'h80000000, 1'b1, 1'b1, p, lat);
        check("ss_minneg_sq", p, 64'h4000000000000000);
        op32(32'h80000000, 32'h80000000, 1'b0, 1'b0, p, lat);
        check("uu_8000_sq", p, 64'h4000000000000000);
        op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, p, lat);
        check("uu_max_sq", p, 64'hFFFFFFFE00000001);
        op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, p, lat);
        check("su_mixed", p, 64'hFFFFFFFF00000001);
        op32(32'd3, 32'hFFFFFFFB, 1'b1, 1'b1, p, lat);
        check("ss_3_m5", p, 64'hFFFFFFFFFFFFFFF1);
        op32(32'h0, 32'h12345678, 1'b1, 1'b1, p, lat);
        check("zero_op", p, 64'h0);
        check("latency32_zero", lat, 34);

        // Directed WIDTH=8 boundaries
        op8(8'h80, 8'h80, 1'b1, 1'b1, p8, lat);
        check("w8_minneg_sq", p8, 16'h4000);
        check("latency8", lat, 10);
        op8(8'hFF, 8'hFF, 1'b0, 1'b0, p8, lat);
        check("w8_uu_max", p8, 16'hFE01);
        op8(8'h7F, 8'h80, 1'b1, 1'b1, p8, lat);
        check("w8_max_x_min", p8, 16'hC080);

        // Start during busy is ignored; prod holds old value during CALC.
        // Previous prod (from zero_op) is 0; use 5*7 first so it is nonzero.
        op32(32'd5, 32'd7, 1'b0, 1'b0, p, lat);
        check("uu_5_7", p, 64'd35);
        @(negedge clk);
        x = 32'd100; y = 32'd200; xs = 1'b0; ys = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 80; i++) begin
            if (i == 4) begin
                check("prod_hold_calc", prod, 64'd35);
                check("busy_in_calc", busy, 1'b1);
            end
            if (i >= 3 && i < 6) begin
                x = 32'd9; y = 32'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                check("ignored_start_prod", prod, 64'd20000);
            end
        end
        start = 1'b0;
        check("one_done_per_start", n_done, 1);

        // Start held high: done every 34 cycles
        @(negedge clk);
        x = 32'hFFFFFFFE; y = 32'd3; xs = 1'b1; ys = 1'b1; start = 1'b1;
        n_done = 0;
        for (int i = 1; i <= 150 && n_done < 3; i++) begin
            @(posedge clk); #1;
            if (done) begin
                t_done[n_done] = i;
                n_done++;
                check("b2b_prod", prod, 64'hFFFFFFFFFFFFFFFA);
                check("b2b_busy_low_in_done", busy, 1'b0);
            end
        end
        start = 1'b0;
        check("b2b_count", n_done, 3);
        if (n_done == 3) begin
            check("b2b_period1", t_done[1] - t_done[0], 34);
            check("b2b_period2", t_done[2] - t_done[1], 34);
        end
        repeat (40) @(posedge clk);

        // Reset during CALC cycle 10 aborts
        @(negedge clk);
        x = 32'd11; y = 32'd13; xs = 1'b0; ys = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_prod", prod, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);

        // Random operands against the exact-product model
        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom;
            ras = 1'($urandom_range(1, 0)); rbs = 1'($urandom_range(1, 0));
            op32(ra, rb, ras, rbs, p, lat);
            check("rand32", p, model32(ra, rb, ras, rbs));
        end
        for (int i = 0; i < 40; i++) begin
            ra8 = 8'($urandom); rb8 = 8'($urandom);
            ras = 1'($urandom_range(1, 0)); rbs = 1'($urandom_range(1, 0));
            op8(ra8, rb8, ras, rbs, p8, lat);
            check("rand8", p8, model8(ra8, rb8, ras, rbs));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
